// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-path types and defaults: datapath width, NOP encoding, reset PC,
// the {pc, instr} fetch entry and the fetch-unit state encoding.
package ifetch_queue_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-unit boundary: ROM read port, redirect port from EX, and the decode handshake.
// master = fetch unit, slave = surrounding ROM / EX / decode.
interface ifetch_queue_if
  import ifetch_queue_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int IMEM_AW = 14
);

  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_rdata;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    out_instr;
  logic               fetch_fault;

  modport master (
    output imem_en, imem_addr, out_valid, out_pc, out_instr, fetch_fault,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_en, imem_addr, out_valid, out_pc, out_instr, fetch_fault,
    output imem_rdata, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Generic DEPTH-entry FIFO with synchronous flush; head visible the cycle after push.
// No internal backpressure: the caller must never push when full (fetch credit logic ensures it).
module ifetch_queue_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic                       head_vld_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;

  assign pop_ok     = pop_i && (count_q != '0);
  assign head_vld_o = (count_q != '0);
  assign head_dat_o = mem_q[rd_q];
  assign count_o    = count_q;

  // Power-of-two depth: pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_ok) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: PC, 1-cycle ROM issue with FIFO credit, redirect/flush.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect faults and halts fetch until an aligned redirect.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              IMEM_AW  = 14,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            armed_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q;
  logic            inflight_q;
  ifetch_state_e   state_q, state_d;
  logic            fault_q, fault_d;
  logic [CW-1:0]   count;
  logic [2*XLEN-1:0] head;
  logic            issue, push, pop;

  // armed_q keeps imem_en low until the first edge after reset release.
  assign issue = armed_q && (state_q == RUN) && !bus.redirect &&
                 ((count + CW'(inflight_q)) < CW'(DEPTH));
  assign push  = inflight_q && !bus.redirect;
  assign pop   = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    pc_d    = pc_q;
    if (bus.redirect) begin
`ifdef IFETCH_ALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = bus.redirect_pc;
        state_d = RUN;
      end
`else
      pc_d = bus.redirect_pc & ~XLEN'(3);
`endif
    end else if (issue) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q    <= 1'b0;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= 1'b0;
      state_q    <= RUN;
      fault_q    <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      pc_q       <= pc_d;
      inflight_q <= issue;
      state_q    <= state_d;
      fault_q    <= fault_d;
      if (issue) resp_pc_q <= pc_q;
    end
  end

  ifetch_queue_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i ({resp_pc_q, bus.imem_rdata}),
    .pop_i      (pop),
    .flush_i    (bus.redirect),
    .head_dat_o (head),
    .head_vld_o (bus.out_valid),
    .count_o    (count)
  );

  assign bus.imem_en     = issue;
  assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
  assign bus.out_pc      = head[2*XLEN-1:XLEN];
  assign bus.out_instr   = head[XLEN-1:0];
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: ROM modelled as mem[i] = 32'h1000_0000 + i, 1-cycle latency.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int XLEN    = 32;
  localparam int IMEM_AW = 14;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ifetch_queue_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW)) bus ();

  ifetch_queue #(
    .XLEN(XLEN), .IMEM_AW(IMEM_AW), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 32'h1000_0000 + 32'(bus.imem_addr);
  end

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {18'b0, pc[15:2]};
  endfunction

  task automatic do_reset(input logic rdy);
    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = rdy;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b0 || bus.fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b imem_en=%b fault=%b, expected 0 0 0",
               bus.out_valid, bus.imem_en, bus.fetch_fault);
    end
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    do_reset(1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_edge1: valid=%b imem_en=%b, expected 0 1", bus.out_valid, bus.imem_en);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_edge2: valid=%b, expected 0", bus.out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      epc = 32'(4 * k);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== epc || bus.out_instr !== rom_word(epc)) begin
        n_fail++;
        $display("FAIL stream_entry%0d: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                 k, bus.out_valid, bus.out_pc, bus.out_instr, epc, rom_word(epc));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] epc;
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 5) begin
        n_checks++;
        if (bus.imem_en !== 1'b0 || bus.out_valid !== 1'b1 ||
            bus.out_pc !== 32'h0 || bus.out_instr !== 32'h1000_0000) begin
          n_fail++;
          $display("FAIL bp_full_hold%0d: imem_en=%b valid=%b pc=%h instr=%h, expected 0 1 pc=0 instr=10000000",
                   i, bus.imem_en, bus.out_valid, bus.out_pc, bus.out_instr);
        end
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      epc = 32'(4 * k);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== epc || bus.out_instr !== rom_word(epc)) begin
        n_fail++;
        $display("FAIL bp_release%0d: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                 k, bus.out_valid, bus.out_pc, bus.out_instr, epc, rom_word(epc));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rdi_pre: valid=%b pc=%h, expected 1 pc=0", bus.out_valid, bus.out_pc);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    @(negedge clk);
    bus.redirect  = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdi_flush: valid=%b, expected 0", bus.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdi_no_stale: valid=%b pc=%h, expected valid 0", bus.out_valid, bus.out_pc);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(32'h40 + 4 * k) ||
          bus.out_instr !== 32'(32'h1000_0010 + k)) begin
        n_fail++;
        $display("FAIL rdi_target%0d: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                 k, bus.out_valid, bus.out_pc, bus.out_instr, 32'(32'h40 + 4 * k), 32'(32'h1000_0010 + k));
      end
    end
  endtask

  task automatic test_redirect_pop();
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8) begin
      n_fail++;
      $display("FAIL rdp_head: valid=%b pc=%h, expected 1 pc=8", bus.out_valid, bus.out_pc);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h80;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdp_consumed_once: valid=%b pc=%h, expected valid 0", bus.out_valid, bus.out_pc);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdp_gap: valid=%b, expected 0", bus.out_valid);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(32'h80 + 4 * k) ||
          bus.out_instr !== 32'(32'h1000_0020 + k)) begin
        n_fail++;
        $display("FAIL rdp_target%0d: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                 k, bus.out_valid, bus.out_pc, bus.out_instr, 32'(32'h80 + 4 * k), 32'(32'h1000_0020 + k));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_pre: valid=%b pc=%h, expected 1 pc=0", bus.out_valid, bus.out_pc);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: valid=%b imem_en=%b, expected 0 0", bus.out_valid, bus.imem_en);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_latency: valid=%b pc=%h, expected valid 0", bus.out_valid, bus.out_pc);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL rst_mid_restart: valid=%b pc=%h instr=%h, expected 1 pc=0 instr=10000000",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_align();
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h42;
    @(negedge clk);
    bus.redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    n_checks++;
    if (bus.fetch_fault !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL align_fault: fault=%b valid=%b, expected 1 0", bus.fetch_fault, bus.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL align_pulse: fault=%b, expected 0", bus.fetch_fault);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL align_halt%0d: valid=%b imem_en=%b, expected 0 0", i, bus.out_valid, bus.imem_en);
      end
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h46;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++;
    if (bus.fetch_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL align_refault: fault=%b, expected 1", bus.fetch_fault);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h44;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++;
    if (bus.fetch_fault !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL align_resume_gap: fault=%b valid=%b, expected 0 0", bus.fetch_fault, bus.out_valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h44 || bus.out_instr !== 32'h1000_0011) begin
      n_fail++;
      $display("FAIL align_resume: valid=%b pc=%h instr=%h, expected 1 pc=44 instr=10000011",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
`else
    n_checks++;
    if (bus.fetch_fault !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL noalign_flush: fault=%b valid=%b, expected 0 0", bus.fetch_fault, bus.out_valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== 32'h1000_0010 ||
        bus.fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL noalign_forced: valid=%b pc=%h instr=%h fault=%b, expected 1 pc=40 instr=10000010 fault=0",
               bus.out_valid, bus.out_pc, bus.out_instr, bus.fetch_fault);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop();
    test_reset_mid();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
